// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - state, opcode and select encodings plus per-state control decode
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EX   = 4'd10,
        ADDI_WB   = 4'd11,
        TRAP      = 4'd12
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} aluOpT;
    typedef enum logic [1:0] {SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11} srcBT;
    typedef enum logic [1:0] {PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10} pcSrcT;

    typedef struct packed {
        logic  pcWrite;
        logic  pcWriteCond;
        logic  iOrD;
        logic  memRead;
        logic  memWrite;
        logic  memToReg;
        logic  regDst;
        logic  regWrite;
        logic  aluSrcA;
        srcBT  aluSrcB;
        aluOpT aluOp;
        pcSrcT pcSource;
        logic  fetch;
        logic  trap;
    } ctrlT;

    function automatic ctrlT ctrlFor(input stateT s);
        ctrlT c;
        c = '0;
        case (s)
            FETCH:     begin c.memRead = 1'b1; c.aluSrcB = SRCB_FOUR; c.fetch = 1'b1; end
            DECODE:    c.aluSrcB = SRCB_IMM_SH2;
            MEM_ADDR:  begin c.aluSrcA = 1'b1; c.aluSrcB = SRCB_IMM; end
            MEM_READ:  begin c.memRead = 1'b1; c.iOrD = 1'b1; end
            MEM_WB:    begin c.regWrite = 1'b1; c.memToReg = 1'b1; end
            MEM_WRITE: begin c.memWrite = 1'b1; c.iOrD = 1'b1; end
            EXECUTE:   begin c.aluSrcA = 1'b1; c.aluOp = ALU_FUNCT; end
            ALU_WB:    begin c.regWrite = 1'b1; c.regDst = 1'b1; end
            BRANCH:    begin
                c.aluSrcA = 1'b1; c.aluOp = ALU_SUB;
                c.pcWriteCond = 1'b1; c.pcSource = PCSRC_ALUOUT;
            end
            JUMP:      begin c.pcWrite = 1'b1; c.pcSource = PCSRC_JUMP; end
            ADDI_EX:   begin c.aluSrcA = 1'b1; c.aluSrcB = SRCB_IMM; end
            ADDI_WB:   c.regWrite = 1'b1;
            TRAP:      c.trap = 1'b1;
            default:   c.trap = 1'b1;
        endcase
        return c;
    endfunction

    function automatic stateT nextState(input stateT s, input logic [5:0] op,
                                        input logic ready, input logic timeout);
        stateT n;
        case (s)
            FETCH:     n = ready ? DECODE : (timeout ? TRAP : FETCH);
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: n = MEM_ADDR;
                    OP_RTYPE:     n = EXECUTE;
                    OP_BEQ:       n = BRANCH;
                    OP_J:         n = JUMP;
                    OP_ADDI:      n = ADDI_EX;
                    default:      n = TRAP;
                endcase
            end
            MEM_ADDR:  n = (op == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  n = ready ? MEM_WB : (timeout ? TRAP : MEM_READ);
            MEM_WRITE: n = ready ? FETCH : (timeout ? TRAP : MEM_WRITE);
            EXECUTE:   n = ALU_WB;
            ADDI_EX:   n = ADDI_WB;
            MEM_WB, ALU_WB, ADDI_WB, BRANCH, JUMP: n = FETCH;
            default:   n = TRAP;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller <-> datapath control bundle
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state_dbg
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op, state_dbg
    );
endinterface

// File: rtl/mc_stall_timer.sv
// rtl/mc_stall_timer.sv - counts consecutive memory-wait cycles and flags a stall timeout
module mc_stall_timer #(
    parameter int STALL_LIMIT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic memReady,
    output logic timeout
);
    localparam int CW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

    logic [CW-1:0] stallCnt;
    logic          stalled;

    assign stalled = waiting && !memReady;

    // Leaving a wait state needs mem_ready or a trap, so clearing on !stalled covers state changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (!stalled) begin
            stallCnt <= '0;
        end else if (!timeout) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    generate
        if (STALL_LIMIT > 0) begin : gLimit
            // stallCnt holds prior stalled cycles; this cycle is the STALL_LIMIT-th one.
            assign timeout = stalled && (stallCnt == CW'(STALL_LIMIT - 1));
        end else begin : gNoLimit
            assign timeout = 1'b0;
        end
    endgenerate
endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle main controller FSM with memory stall trap
// Optional MULTICYCLE_PERF_CNT_EN adds cycle_cnt / instr_cnt outputs.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int STALL_LIMIT = 0,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instr_cnt
`endif
);
    stateT state;
    stateT nextSt;
    ctrlT  ctrl;
    logic  waiting;
    logic  timeout;
    logic  fetchDone;
    logic  unusedInputs;

    assign unusedInputs = ^{bus.funct, bus.zero};
    assign waiting      = state inside {FETCH, MEM_READ, MEM_WRITE};

    mc_stall_timer #(.STALL_LIMIT(STALL_LIMIT)) uStall (
        .clk      (clk),
        .rst_n    (rst_n),
        .waiting  (waiting),
        .memReady (bus.mem_ready),
        .timeout  (timeout)
    );

    assign nextSt = nextState(state, bus.opcode, bus.mem_ready, timeout);

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            ctrl  <= ctrlFor(FETCH);
        end else begin
            state <= nextSt;
            ctrl  <= ctrlFor(nextSt);
        end
    end

    // Fetch completion follows mem_ready within the cycle; rst_n gates requests during reset.
    assign fetchDone         = ctrl.fetch & bus.mem_ready & rst_n;
    assign bus.pc_write      = ctrl.pcWrite | fetchDone;
    assign bus.ir_write      = fetchDone;
    assign bus.mem_read      = ctrl.memRead & rst_n;
    assign bus.pc_write_cond = ctrl.pcWriteCond;
    assign bus.i_or_d        = ctrl.iOrD;
    assign bus.mem_write     = ctrl.memWrite;
    assign bus.mem_to_reg    = ctrl.memToReg;
    assign bus.reg_dst       = ctrl.regDst;
    assign bus.reg_write     = ctrl.regWrite;
    assign bus.alu_src_a     = ctrl.aluSrcA;
    assign bus.alu_src_b     = ctrl.aluSrcB;
    assign bus.alu_op        = ctrl.aluOp;
    assign bus.pc_source     = ctrl.pcSource;
    assign bus.illegal_op    = ctrl.trap;
    assign bus.state_dbg     = state;

`ifdef MULTICYCLE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state != TRAP) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            if (nextSt == FETCH && state != FETCH) begin
                instr_cnt <= instr_cnt + 1'b1;
            end
        end
    end
`else
    localparam int unusedCntW = CNT_W;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;
    logic clk;
    logic rst_n;
    int   nChecks = 0;
    int   nErrors = 0;

    multicycle_control_if bus0 ();
    multicycle_control_if bus5 ();

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycleCnt0, instrCnt0, cycleCnt5, instrCnt5;
    multicycle_control #(.STALL_LIMIT(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.master), .cycle_cnt(cycleCnt0), .instr_cnt(instrCnt0));
    multicycle_control #(.STALL_LIMIT(5), .CNT_W(32)) dut5 (
        .clk(clk), .rst_n(rst_n), .bus(bus5.master), .cycle_cnt(cycleCnt5), .instr_cnt(instrCnt5));
`else
    multicycle_control #(.STALL_LIMIT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
    multicycle_control #(.STALL_LIMIT(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5.master));
`endif

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
    //  reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source[1:0], illegal_op}
    logic [16:0] ctl0;
    assign ctl0 = {bus0.pc_write, bus0.pc_write_cond, bus0.i_or_d, bus0.mem_read, bus0.mem_write,
                   bus0.ir_write, bus0.mem_to_reg, bus0.reg_dst, bus0.reg_write, bus0.alu_src_a,
                   bus0.alu_src_b, bus0.alu_op, bus0.pc_source, bus0.illegal_op};

    localparam logic [16:0] E_RESET   = {10'b0000000000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_FETCH_W = {10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_FETCH_R = {10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_DECODE  = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_MADDR   = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_MREAD   = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_MWB     = {10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_MWRITE  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_EXEC    = {10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [16:0] E_ALUWB   = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_BRANCH  = {10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [16:0] E_JUMP    = {10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [16:0] E_ADDIEX  = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_ADDIWB  = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] E_TRAP    = {10'b0000000000, 2'b00, 2'b00, 2'b00, 1'b1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nErrors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a falling edge: check the current cycle of dut0, then move to the next falling edge.
    task automatic at(input string tag, input logic [3:0] st, input logic [16:0] ctl);
        #1;
        chk({tag, ".state"}, {28'd0, bus0.state_dbg}, {28'd0, st});
        chk({tag, ".ctl"}, {15'd0, ctl0}, {15'd0, ctl});
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1;
        bus0.opcode = 6'b000000; bus0.funct = 6'b100000; bus0.zero = 1'b0; bus0.mem_ready = 1'b1;
        bus5.opcode = 6'b000000; bus5.funct = 6'b100000; bus5.zero = 1'b0; bus5.mem_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset.state", {28'd0, bus0.state_dbg}, 32'd0);
        chk("reset.ctl", {15'd0, ctl0}, {15'd0, E_RESET});
        chk("reset.state5", {28'd0, bus5.state_dbg}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // R-type, zero-wait memory: 0,1,6,7
        at("r.fetch", 4'd0, E_FETCH_R);
        at("r.decode", 4'd1, E_DECODE);
        at("r.exec", 4'd6, E_EXEC);
        at("r.wb", 4'd7, E_ALUWB);
`ifdef MULTICYCLE_PERF_CNT_EN
        chk("perf.instr", instrCnt0, 32'd1);
        chk("perf.cycle", cycleCnt0, 32'd4);
`endif

        // lw with three wait cycles in MEM_READ: 8 cycles total
        bus0.opcode = 6'b100011;
        at("lw.fetch", 4'd0, E_FETCH_R);
        at("lw.decode", 4'd1, E_DECODE);
        at("lw.addr", 4'd2, E_MADDR);
        bus0.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) at("lw.stall", 4'd3, E_MREAD);
        bus0.mem_ready = 1'b1;
        at("lw.read", 4'd3, E_MREAD);
        at("lw.wb", 4'd4, E_MWB);

        bus0.opcode = 6'b101011;
        at("sw.fetch", 4'd0, E_FETCH_R);
        at("sw.decode", 4'd1, E_DECODE);
        at("sw.addr", 4'd2, E_MADDR);
        at("sw.write", 4'd5, E_MWRITE);

        bus0.opcode = 6'b000100;
        bus0.zero = 1'b1;
        at("beq1.fetch", 4'd0, E_FETCH_R);
        at("beq1.decode", 4'd1, E_DECODE);
        at("beq1.branch", 4'd8, E_BRANCH);
        bus0.zero = 1'b0;
        at("beq0.fetch", 4'd0, E_FETCH_R);
        at("beq0.decode", 4'd1, E_DECODE);
        at("beq0.branch", 4'd8, E_BRANCH);

        bus0.opcode = 6'b000010;
        at("j.fetch", 4'd0, E_FETCH_R);
        at("j.decode", 4'd1, E_DECODE);
        at("j.jump", 4'd9, E_JUMP);

        bus0.opcode = 6'b001000;
        at("addi.fetch", 4'd0, E_FETCH_R);
        at("addi.decode", 4'd1, E_DECODE);
        at("addi.ex", 4'd10, E_ADDIEX);
        at("addi.wb", 4'd11, E_ADDIWB);

        // No timeout when STALL_LIMIT is 0
        bus0.mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) at("nolimit.stall", 4'd0, E_FETCH_W);

        // Illegal opcode traps after DECODE and stays there
        bus0.mem_ready = 1'b1;
        bus0.opcode = 6'b111111;
        at("ill.fetch", 4'd0, E_FETCH_R);
        at("ill.decode", 4'd1, E_DECODE);
        for (int i = 0; i < 20; i++) begin
            bus0.mem_ready = i[0];
            at("ill.trap", 4'd12, E_TRAP);
        end
        bus0.mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("ill.rst.state", {28'd0, bus0.state_dbg}, 32'd0);
        chk("ill.rst.ctl", {15'd0, ctl0}, {15'd0, E_RESET});
        @(negedge clk);
        rst_n = 1'b1;

        // Reset asserted during MEM_WRITE with mem_ready high
        bus0.opcode = 6'b101011;
        at("swr.fetch", 4'd0, E_FETCH_R);
        at("swr.decode", 4'd1, E_DECODE);
        at("swr.addr", 4'd2, E_MADDR);
        #1;
        chk("swr.pre.mem_write", {31'd0, bus0.mem_write}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("swr.rst.mem_write", {31'd0, bus0.mem_write}, 32'd0);
        chk("swr.rst.state", {28'd0, bus0.state_dbg}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // STALL_LIMIT=5: five stalled FETCH cycles trap
        bus5.mem_ready = 1'b0;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk("lim.stall.state", {28'd0, bus5.state_dbg}, 32'd0);
            @(negedge clk);
        end
        #1;
        chk("lim.trap.state", {28'd0, bus5.state_dbg}, 32'd12);
        chk("lim.trap.illegal", {31'd0, bus5.illegal_op}, 32'd1);
        @(negedge clk);

        // mem_ready on the fifth stalled cycle wins over the timeout
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("lim2.stall.state", {28'd0, bus5.state_dbg}, 32'd0);
            @(negedge clk);
        end
        bus5.mem_ready = 1'b1;
        #1;
        chk("lim2.ready.ir_write", {31'd0, bus5.ir_write}, 32'd1);
        @(negedge clk);
        #1;
        chk("lim2.decode.state", {28'd0, bus5.state_dbg}, 32'd1);
        chk("lim2.decode.illegal", {31'd0, bus5.illegal_op}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main controller that sequences the shared datapath (register file, ALU, unified instruction/data memory, PC) over multiple cycles per instruction.
- Sits beside the datapath and drives every enable and mux select from the current state plus the decoded opcode.
- Handles variable-latency memory through a ready handshake.
- Traps permanently on illegal opcodes and on memory stall timeout.

Parameters:
- STALL_LIMIT, default 0: maximum wait cycles for mem_ready in any memory state. 0 disables the timeout.
- CNT_W, default 32: width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction register bits [31:26]
- funct  in  6  instruction register bits [5:0]; accepted, not decoded by this block (ALU decoder owns it)
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load when zero=1
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  write-data select: 0=ALUOut, 1=MDR
- reg_dst  out  1  destination select: 0=rt, 1=rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=4, 10=sign-extended immediate, 11=sign-extended immediate shifted left 2
- alu_op  out  2  00=add, 01=sub, 10=use funct
- pc_source  out  2  00=ALU, 01=ALUOut, 10=jump target
- illegal_op  out  1  sticky trap flag
- state_dbg  out  4  current state encoding

Behaviour:
- Reset: rst_n low asynchronously forces the state to FETCH, clears the stall counter and clears illegal_op.
  - While rst_n is low, all write/request outputs are forced to 0: pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write.
  - While rst_n is low, the selects take their FETCH values: i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. All other selects are 0.
- Any output not listed for a state is 0.
- Transitions by state:
  - FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write are asserted only in the cycle mem_ready=1, which also moves to DECODE. Otherwise stay in FETCH.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - 100011 (lw) and 101011 (sw) go to MEM_ADDR.
    - 000000 goes to EXECUTE.
    - 000100 (beq) goes to BRANCH.
    - 000010 (j) goes to JUMP.
    - 001000 (addi) goes to ADDI_EX.
    - Any other opcode goes to TRAP.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw goes to MEM_READ, sw goes to MEM_WRITE.
  - MEM_READ: mem_read=1, i_or_d=1. Stay until mem_ready, then go to MEM_WB.
  - MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
  - MEM_WRITE: mem_write=1, i_or_d=1. Stay until mem_ready, then go to FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALU_WB.
  - ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Go to FETCH.
  - JUMP: pc_write=1, pc_source=10. Go to FETCH.
  - ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDI_WB.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
  - TRAP: all enables 0 and illegal_op=1. Terminal; only reset exits.
- Cycle counts with zero-wait memory: R-type and addi 4, lw 5, sw 4, beq 3, j 3.
- Stall counter:
  - Counts consecutive cycles in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - When STALL_LIMIT>0 and the count reaches STALL_LIMIT with mem_ready still 0, the next state is TRAP.
  - If mem_ready=1 arrives in that same cycle, it wins and the access completes.
- Reset mid-instruction abandons the instruction immediately. No partial writes occur after rst_n falls.
- Write enables (reg_write, mem_write, ir_write) are never asserted in the same cycle, which guarantees a single writer per resource.

Optional Feature:
- Macro: MULTICYCLE_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt and instr_cnt, each CNT_W wide, both 0 on reset.
  - cycle_cnt increments every cycle outside TRAP.
  - instr_cnt increments on each transition into FETCH from another state (instruction retired).
  - Both counters wrap modulo 2^CNT_W.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package multicycle_pkg holds:
  - state typedef with 4-bit encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, TRAP=12.
  - opcode constants.
  - alu_op, alu_src_b and pc_source encodings.
- One sub-module, mc_stall_timer: stall counter plus timeout compare.

Test Plan:
- Reset, then feed opcode 000000 with mem_ready tied 1 -> states 0,1,6,7,0. reg_write=1 with reg_dst=1 only in state 7. instr_cnt=1 after 4 cycles when the feature is enabled.
- lw with mem_ready low for 3 cycles in MEM_READ -> state holds at 3 for 3 cycles, mem_read=1 throughout, then MEM_WB with reg_write=1 and mem_to_reg=1. Total 8 cycles.
- beq with zero=1, then with zero=0 -> pc_write_cond=1 and pc_source=01 in BRANCH for both runs, pc_write stays 0. 3 cycles each.
- opcode 111111 -> TRAP after DECODE, illegal_op=1, all enables 0 for 20 cycles. rst_n pulse -> FETCH and illegal_op=0.
- STALL_LIMIT=5, mem_ready held 0 in FETCH -> TRAP after exactly 5 stalled cycles. Repeat with mem_ready=1 on the 5th cycle -> DECODE, no trap.
- Assert rst_n low during MEM_WRITE with mem_ready=1 -> mem_write drops to 0 asynchronously and the state reads 0 in the same cycle.
